// File: rtl/melody_tone_sequencer.sv
// ---------------------------------------------------------------------------
// melody_tone_sequencer
//
// Purpose: ROM-driven melody player. Each ROM word holds a tone half-period
// (in clocks, minus 1). The player steps through the ROM one note per beat
// and produces a square-wave PCM sample pair. It supports start/stop/pause,
// loop or one-shot playback, rests (half-period 0), an end-of-song marker
// (an all-ones word) and volume attenuation by arithmetic right shift.
//
// Ports:
//   CLOCK_50          in   system clock
//   resetn            in   asynchronous active-low reset
//   start             in   level; begin playback at address 0 from IDLE/DONE
//   stop              in   level; abort to IDLE (highest priority)
//   pause             in   level; freeze playback while high
//   loop_en           in   1 = wrap to address 0 at end of song, 0 = one-shot
//   volume[2:0]       in   attenuation shift applied to AMPLITUDE
//   rom_addr          out  note ROM address
//   rom_q             in   note ROM data, valid 2 clocks after rom_addr changes
//   audio_out_allowed in   downstream FIFO has room
//   write_audio_out   out  sample write strobe
//   left_sample       out  left-channel sample
//   right_sample      out  right-channel sample (same as left)
//   playing           out  high in FETCH, WAIT, PLAY, PAUSED
//   done              out  high in DONE
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | stopped, silent; waits for start
// FETCH  | rom_addr presented to the ROM (1 clock)
// WAIT   | ROM read latency (2 clocks); half-period latched on the last one
// PLAY   | tone generation; beat counter runs
// PAUSED | counters and address frozen, silent
// DONE   | one-shot song finished, silent; waits for start
// ---------------------------------------------------------------------------
module melody_tone_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int ROM_DEPTH   = 1000,
  parameter int HP_W        = 19,
  parameter int BEAT_CYCLES = 2500000,
  parameter int SAMPLE_W    = 32,
  parameter int AMPLITUDE   = 100000000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                loop_en,
  input  logic [2:0]          volume,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [HP_W-1:0]     rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [SAMPLE_W-1:0] left_sample,
  output logic [SAMPLE_W-1:0] right_sample,
  output logic                playing,
  output logic                done
);

  localparam int BEAT_W = $clog2(BEAT_CYCLES);
  // Last PLAY beat count of a note; the remaining 3 clocks of the beat are
  // spent in FETCH/WAIT for the next note.
  localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(BEAT_CYCLES - 4);
  localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [SAMPLE_W-1:0] AMP_VAL   = SAMPLE_W'(AMPLITUDE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_PLAY   = 3'd3,
    S_PAUSED = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [HP_W-1:0]     tone_cnt_q, tone_cnt_d;
  logic [HP_W-1:0]     half_per_q, half_per_d;
  logic                phase_q,    phase_d;
  logic                wait_q,     wait_d;
  logic [SAMPLE_W-1:0] sample_q,   sample_d;

  logic                play_step;
  logic                song_end;
  logic [SAMPLE_W-1:0] mag;

  // AMPLITUDE is positive, so a logical shift equals the arithmetic one.
  assign mag = AMP_VAL >> volume;

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      beat_cnt_q <= '0;
      tone_cnt_q <= '0;
      half_per_q <= '0;
      phase_q    <= 1'b0;
      wait_q     <= 1'b0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      beat_cnt_q <= beat_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      half_per_q <= half_per_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      sample_q   <= sample_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    beat_cnt_d = beat_cnt_q;
    tone_cnt_d = tone_cnt_q;
    half_per_d = half_per_q;
    phase_d    = phase_q;
    wait_d     = 1'b0;
    sample_d   = sample_q;
    play_step  = 1'b0;
    song_end   = 1'b0;

    if (stop) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      beat_cnt_d = '0;
      tone_cnt_d = '0;
      half_per_d = '0;
      phase_d    = 1'b0;
      sample_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_FETCH;
            rom_addr_d = '0;
            beat_cnt_d = '0;
            tone_cnt_d = '0;
            phase_d    = 1'b0;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (!wait_q) begin
            wait_d = 1'b1;
          end else begin
            beat_cnt_d = '0;
            tone_cnt_d = '0;
            phase_d    = 1'b0;
            if (&rom_q) begin
              song_end = 1'b1;
            end else begin
              half_per_d = rom_q;
              state_d    = S_PLAY;
            end
          end
        end
        S_PLAY: begin
          if (pause) begin
            state_d  = S_PAUSED;
            sample_d = '0;
          end else begin
            play_step = 1'b1;
          end
        end
        S_PAUSED: begin
          // The release clock already counts as a playing clock, so a pause
          // stretches the note by exactly the number of clocks pause was high.
          if (pause) begin
            sample_d = '0;
          end else begin
            state_d   = S_PLAY;
            play_step = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (play_step) begin
        if (tone_cnt_q == half_per_q) begin
          tone_cnt_d = '0;
          phase_d    = ~phase_q;
        end else begin
          tone_cnt_d = tone_cnt_q + 1'b1;
        end

        if (half_per_q == '0) begin
          phase_d  = 1'b0;
          sample_d = '0;
        end else begin
          sample_d = phase_q ? mag : ('0 - mag);
        end

        if (beat_cnt_q == BEAT_LAST) begin
          if (rom_addr_q == ADDR_LAST) begin
            song_end = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = S_FETCH;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end

      if (song_end) begin
        beat_cnt_d = '0;
        tone_cnt_d = '0;
        phase_d    = 1'b0;
        if (loop_en) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end else begin
          state_d  = S_DONE;
          sample_d = '0;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    playing = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_FETCH, S_WAIT, S_PLAY, S_PAUSED: playing = 1'b1;
      S_DONE:                            done    = 1'b1;
      default: ;
    endcase
    // Silence keeps the FIFO fed while idle; reset gates the strobe immediately.
    write_audio_out = audio_out_allowed & resetn;
    rom_addr        = rom_addr_q;
    left_sample     = sample_q;
    right_sample    = sample_q;
  end

endmodule

// File: tb/tb_melody_tone_sequencer.sv
module tb_melody_tone_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, stop, pause, loop_en;
  logic [2:0]  volume;
  logic [1:0]  rom_addr;
  logic [18:0] rom_q;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_sample, right_sample;
  logic        playing, done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    string       nm;
    logic [31:0] smp;
    bit          pl;
    bit          dn;
    bit          wr;
    bit          ca;
    logic [1:0]  addr;
  } exp_t;

  exp_t sb[$];

  logic [18:0] rom [0:3] = '{19'd3, 19'd0, 19'd1, 19'h7FFFF};
  logic [1:0]  addr_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-clock ROM: address register then output register.
  always @(posedge clk) begin
    addr_r <= rom_addr;
    rom_q  <= rom[addr_r];
  end

  melody_tone_sequencer #(
    .ADDR_W(2), .ROM_DEPTH(4), .HP_W(19), .BEAT_CYCLES(20),
    .SAMPLE_W(32), .AMPLITUDE(1000)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .volume(volume), .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_sample(left_sample), .right_sample(right_sample),
    .playing(playing), .done(done)
  );

  // Square-wave value of note j on its k-th PLAY clock (ROM half-periods 3,0,1).
  function automatic logic [31:0] note_val(input int j, input int k, input int mag);
    int hp;
    hp = (j == 0) ? 3 : (j == 1) ? 0 : 1;
    if (hp == 0) return 32'd0;
    return (((k / (hp + 1)) % 2) == 1) ? 32'(mag) : 32'(-mag);
  endfunction

  // Expected outputs n clocks after the start edge. A note spans 20 clocks:
  // 3 fetch clocks plus the latch clock hold the previous sample, then 16+1
  // PLAY values. The end marker costs 3 more clocks, so the loop is 63 long.
  function automatic void song(input int n, input bit lp, input int ma, input int mb,
                               input int sw, output logic [31:0] smp, output logic [1:0] addr,
                               output bit pl, output bit dn, output bit ca);
    int it, m, j, r, pj, src, mg;
    if (!lp && n >= 63) begin
      smp = '0; addr = '0; pl = 1'b0; dn = 1'b1; ca = 1'b0;
      return;
    end
    it = n / 63; m = n % 63; j = m / 20; r = m % 20;
    pl = 1'b1; dn = 1'b0; ca = 1'b1; addr = 2'(j);
    if (j == 3 || r < 4) begin
      if (j == 0 && it == 0) begin
        smp = '0;
      end else begin
        pj  = (j == 0) ? 2 : j - 1;
        src = (j == 0) ? it * 63 - 3 : it * 63 + 20 * j;
        mg  = (src >= sw) ? mb : ma;
        smp = note_val(pj, 16, mg);
      end
    end else begin
      mg  = (n >= sw) ? mb : ma;
      smp = note_val(j, r - 4, mg);
    end
  endfunction

  task automatic push(input int c, input string nm, input logic [31:0] s, input bit pl,
                      input bit dn, input bit wr, input bit ca, input logic [1:0] a);
    exp_t e;
    e.cyc = c; e.nm = nm; e.smp = s; e.pl = pl; e.dn = dn; e.wr = wr; e.ca = ca; e.addr = a;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int c, input string nm);
    push(c, nm, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
  endtask

  // pause_at < 0: no pause; otherwise pause is high for 7 clocks from that clock.
  task automatic push_song(input int c0, input int n1, input bit lp, input int ma,
                           input int mb, input int sw, input int pause_at, input string tag);
    for (int n = 0; n <= n1; n++) begin
      logic [31:0] s;
      logic [1:0]  a;
      bit          pl, dn, ca;
      int          ns;
      if (pause_at >= 0 && n > pause_at && n <= pause_at + 7) begin
        push(c0 + n, $sformatf("%s n=%0d paused", tag, n), 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
      end else begin
        ns = (pause_at >= 0 && n > pause_at + 7) ? n - 7 : n;
        song(ns, lp, ma, mb, sw, s, a, pl, dn, ca);
        push(c0 + n, $sformatf("%s n=%0d", tag, n), s, pl, dn, 1'b1, ca, a);
      end
    end
  endtask

  task automatic at_edge(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk(input string nm, input string what, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %0d want %0d", nm, what, $signed(got), $signed(want));
    end
  endtask

  // Monitor: compares the DUT outputs against each entry in its due clock.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missed: checked at cycle %0d, required %0d", e.nm, cyc, e.cyc);
        end else begin
          chk(e.nm, "left", left_sample, e.smp);
          chk(e.nm, "right", right_sample, e.smp);
          chk(e.nm, "playing", 32'(playing), 32'(e.pl));
          chk(e.nm, "done", 32'(done), 32'(e.dn));
          chk(e.nm, "write", 32'(write_audio_out), 32'(e.wr));
          if (e.ca) chk(e.nm, "addr", 32'(rom_addr), 32'(e.addr));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    int c0, cur;
    resetn = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    volume = 3'd0; audio_out_allowed = 1'b1;
    #2 resetn = 1'b0;

    // Reset state, then idle after release (start required to play).
    @(posedge clk); #1;
    push(cyc, "reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) push_idle(cyc + i, $sformatf("idle %0d", i));
    drain();

    // One-shot song at full volume, then start+stop together while DONE.
    c0 = cyc + 1;
    push_song(c0, 69, 1'b0, 1000, 1000, 0, -1, "oneshot");
    start = 1'b1;
    at_edge(c0);
    start = 1'b0;
    at_edge(c0 + 69);
    cur = cyc;
    push_idle(cur + 1, "start+stop");
    start = 1'b1; stop = 1'b1;
    at_edge(cur + 1);
    start = 1'b0; stop = 1'b0;
    push_idle(cur + 2, "after start+stop a");
    push_idle(cur + 3, "after start+stop b");
    drain();

    // Looping song: wraps to address 0 and replays; then stop.
    loop_en = 1'b1;
    c0 = cyc + 1;
    push_song(c0, 99, 1'b1, 1000, 1000, 0, -1, "loop");
    start = 1'b1;
    at_edge(c0);
    start = 1'b0;
    at_edge(c0 + 99);
    stop = 1'b1;
    push_idle(c0 + 100, "stop in loop");
    at_edge(c0 + 100);
    stop = 1'b0;
    loop_en = 1'b0;
    drain();

    // Volume 2 then 3 mid-note.
    volume = 3'd2;
    c0 = cyc + 1;
    push_song(c0, 18, 1'b0, 250, 125, 10, -1, "volume");
    start = 1'b1;
    at_edge(c0);
    start = 1'b0;
    at_edge(c0 + 9);
    volume = 3'd3;
    at_edge(c0 + 18);
    stop = 1'b1;
    push_idle(c0 + 19, "stop after volume");
    at_edge(c0 + 19);
    stop = 1'b0;
    volume = 3'd0;
    drain();

    // Pause for 7 clocks mid-note: silence, then the note ends 7 clocks late.
    c0 = cyc + 1;
    push_song(c0, 40, 1'b0, 1000, 1000, 0, 10, "pause");
    start = 1'b1;
    at_edge(c0);
    start = 1'b0;
    at_edge(c0 + 10);
    pause = 1'b1;
    at_edge(c0 + 17);
    pause = 1'b0;
    at_edge(c0 + 40);
    stop = 1'b1;
    push_idle(c0 + 41, "stop after pause");
    at_edge(c0 + 41);
    stop = 1'b0;
    drain();

    // Stop while waiting on the ROM for note 1: back to IDLE with address 0.
    c0 = cyc + 1;
    push_song(c0, 21, 1'b0, 1000, 1000, 0, -1, "stopwait");
    start = 1'b1;
    at_edge(c0);
    start = 1'b0;
    at_edge(c0 + 21);
    stop = 1'b1;
    push_idle(c0 + 22, "stop in wait");
    at_edge(c0 + 22);
    stop = 1'b0;
    drain();

    // Write strobe follows audio_out_allowed.
    cur = cyc;
    audio_out_allowed = 1'b0;
    push(cur, "no room", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    at_edge(cur + 1);
    audio_out_allowed = 1'b1;
    push_idle(cur + 1, "room again");
    drain();

    // Reset in the middle of PLAY: outputs clear in the same clock.
    c0 = cyc + 1;
    push_song(c0, 29, 1'b0, 1000, 1000, 0, -1, "prereset");
    start = 1'b1;
    at_edge(c0);
    start = 1'b0;
    at_edge(c0 + 30);
    resetn = 1'b0;
    push(c0 + 30, "reset mid-play", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    at_edge(c0 + 32);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) push_idle(c0 + 32 + i, $sformatf("post-reset idle %0d", i));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
